// File: rtl/mos_param.sv
// mos_param: signed C = X*W over an NxN problem (N in {2,4,8}), emits anti-diagonal sums D[0..2N-2].
// Latency: first D valid N*N+3 cycles after the last X beat is accepted, then one D per transfer.
// Backpressure: in_ready is low outside the load phases; out_valid/out_data hold until out_ready.
module mos_param #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int MAX_N  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [1:0]               i_matrix_size,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [DATA_W-1:0]        i_in_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic signed [ACC_W-1:0]  o_out_data
);

  localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int NW    = IDX_W + 1;      // holds N itself
  localparam int DW    = IDX_W + 1;      // diagonal index 0..2N-2
  localparam int ND    = 2 * MAX_N - 1;  // number of diagonals
  localparam int CW    = 2 * IDX_W + 2;  // CALC counter reaches N*N+2
  localparam int PW    = 2 * DATA_W;     // full-precision product

  localparam logic [1:0] S_LOAD_W = 2'd0;
  localparam logic [1:0] S_LOAD_X = 2'd1;
  localparam logic [1:0] S_CALC   = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  // Map the size code to N, clamping anything above MAX_N
  function automatic logic [NW-1:0] f_size_to_n(input logic [1:0] sz);
    int n;
    case (sz)
      2'd0:    n = 2;
      2'd1:    n = 4;
      2'd2:    n = 8;
      default: n = MAX_N;
    endcase
    if (n > MAX_N) n = MAX_N;
    return NW'(n);
  endfunction

  logic [1:0]              r_state;
  logic [NW-1:0]           r_n;
  logic [IDX_W-1:0]        r_row;
  logic [IDX_W-1:0]        r_col;
  logic [CW-1:0]           r_cnt;
  logic [DW-1:0]           r_diag;
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_out_data;

  logic signed [DATA_W-1:0] r_w [MAX_N][MAX_N];
  logic signed [DATA_W-1:0] r_x [MAX_N][MAX_N];

  logic                    r_v1;
  logic [DW-1:0]           r_d1;
  logic signed [PW-1:0]    r_prod [MAX_N];
  logic                    r_v2;
  logic [DW-1:0]           r_d2;
  logic signed [ACC_W-1:0] r_sum;
  logic signed [ACC_W-1:0] r_acc [ND];

  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_first;
  logic [NW-1:0]           w_n;
  logic [NW-1:0]           w_nm1;
  logic                    w_last;
  logic [CW-1:0]           w_nn;
  logic                    w_issue;
  logic                    w_step;
  logic [DW-1:0]           w_dmax;
  logic [DW-1:0]           w_diag_nx;
  logic signed [PW-1:0]    w_prod [MAX_N];
  logic signed [ACC_W-1:0] w_ext  [MAX_N];
  logic signed [ACC_W-1:0] w_sum;

  assign w_in_ready = (r_state == S_LOAD_W) || (r_state == S_LOAD_X);
  assign w_accept   = i_in_valid && w_in_ready;
  // The very first W beat carries the size; use it before it is registered
  assign w_first    = (r_state == S_LOAD_W) && (r_row == '0) && (r_col == '0);
  assign w_n        = w_first ? f_size_to_n(i_matrix_size) : r_n;
  assign w_nm1      = w_n - NW'(1);
  assign w_last     = ({1'b0, r_row} == w_nm1) && ({1'b0, r_col} == w_nm1);
  assign w_nn       = CW'(r_n) * CW'(r_n);
  assign w_issue    = (r_state == S_CALC) && (r_cnt < w_nn);
  assign w_step     = w_accept || w_issue;
  assign w_dmax     = DW'({r_n, 1'b0} - (NW + 1)'(2));
  assign w_diag_nx  = r_diag + DW'(1);

  // N parallel signed multiplies for the (row, col) pair being issued; lanes >= N contribute 0
  for (genvar k = 0; k < MAX_N; k++) begin : g_mul
    localparam logic [NW-1:0] LP_K = NW'(k);
    assign w_prod[k] = (LP_K < r_n) ? (PW'(r_x[r_row][k]) * PW'(r_w[k][r_col])) : '0;
    assign w_ext[k]  = {{(ACC_W - PW){r_prod[k][PW-1]}}, r_prod[k]};
  end

  // Sum the registered products into one C[i][j]
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < MAX_N; k++) begin
      w_sum = w_sum + w_ext[k];
    end
  end

  // Store accepted beats into W or X at the current (row, col)
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_accept) begin
      if (r_state == S_LOAD_W) r_w[r_row][r_col] <= i_in_data;
      else                     r_x[r_row][r_col] <= i_in_data;
    end
  end

  // Pipeline stage 1: products and target diagonal of the issued pair
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1   <= 1'b0;
      r_d1   <= '0;
      r_prod <= '{default: '0};
    end else begin
      r_v1   <= w_issue;
      r_d1   <= {1'b0, r_row} + {1'b0, r_col};
      r_prod <= w_prod;
    end
  end

  // Pipeline stage 2: reduced C[i][j]
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v2  <= 1'b0;
      r_d2  <= '0;
      r_sum <= '0;
    end else begin
      r_v2  <= r_v1;
      r_d2  <= r_d1;
      r_sum <= w_sum;
    end
  end

  // Diagonal accumulators: cleared on entry to CALC, then C[i][j] added into acc[i+j]
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '{default: '0};
    end else if ((r_state == S_LOAD_X) && w_accept && w_last) begin
      r_acc <= '{default: '0};
    end else if (r_v2) begin
      r_acc[r_d2] <= r_acc[r_d2] + r_sum;
    end
  end

  // Control FSM: beat/issue counters, state sequencing and the output register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_LOAD_W;
      r_n         <= NW'(2);
      r_row       <= '0;
      r_col       <= '0;
      r_cnt       <= '0;
      r_diag      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_step) begin
        if ({1'b0, r_col} == w_nm1) begin
          r_col <= '0;
          r_row <= ({1'b0, r_row} == w_nm1) ? '0 : r_row + IDX_W'(1);
        end else begin
          r_col <= r_col + IDX_W'(1);
        end
      end
      case (r_state)
        S_LOAD_W: begin
          if (w_accept) begin
            if (w_first) r_n <= w_n;
            if (w_last)  r_state <= S_LOAD_X;
          end
        end
        S_LOAD_X: begin
          if (w_accept && w_last) begin
            r_state <= S_CALC;
            r_cnt   <= '0;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CW'(1);
          // Last pair has left the accumulate stage one cycle earlier
          if (r_cnt == w_nn + CW'(2)) begin
            r_state     <= S_OUT;
            r_diag      <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= r_acc[0];
          end
        end
        S_OUT: begin
          if (i_out_ready) begin
            if (r_diag == w_dmax) begin
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_state     <= S_LOAD_W;
            end else begin
              r_diag     <= w_diag_nx;
              r_out_data <= r_acc[w_diag_nx];
            end
          end
        end
        default: r_state <= S_LOAD_W;
      endcase
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_mos_param.sv
// tb_mos_param: directed problems against hand-computed anti-diagonal sums.
// Covers reset state, 2x2/4x4/8x8 results, output timing, gaps, back-pressure,
// reset mid-CALC and back-to-back problems.
module tb_mos_param;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 40;
  localparam int MAX_N  = 8;

  logic                    i_clk = 1'b0;
  logic                    i_rst = 1'b1;
  logic [1:0]              i_matrix_size = 2'd0;
  logic                    i_in_valid = 1'b0;
  logic [DATA_W-1:0]       i_in_data = '0;
  logic                    i_out_ready = 1'b1;
  logic                    o_in_ready;
  logic                    o_out_valid;
  logic signed [ACC_W-1:0] o_out_data;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int viol  = 0;
  longint q_dat[$];
  int     q_cyc[$];
  longint exp_d[15];
  logic [DATA_W-1:0] gw[64];
  logic [DATA_W-1:0] gx[64];

  mos_param #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_N(MAX_N)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_matrix_size(i_matrix_size),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Record every output transfer and watch the handshake invariants
  always @(negedge i_clk) begin
    if (o_out_valid && i_out_ready) begin
      q_dat.push_back(longint'(o_out_data));
      q_cyc.push_back(cyc);
    end
    if (o_in_ready && o_out_valid) viol++;
    if (!o_out_valid && (o_out_data != '0)) viol++;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one beat (called just after a rising edge) and hold it until accepted
  task automatic put(input logic [DATA_W-1:0] v, output int t_acc);
    bit ok;
    ok = 1'b0;
    t_acc = 0;
    i_in_valid = 1'b1;
    i_in_data  = v;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge i_clk);
      ok    = o_in_ready;
      t_acc = cyc + 1;
      @(posedge i_clk); #1;
    end
    if (!ok) chk("put_timeout", 1, 0);
    i_in_valid = 1'b0;
  endtask

  // Stream W then X; t_last is the edge that accepted the final X beat
  task automatic load(input logic [1:0] msz, input int n, input bit gap, output int t_last);
    int t;
    t = 0;
    @(posedge i_clk); #1;
    i_matrix_size = msz;
    for (int b = 0; b < 2 * n * n; b++) begin
      put((b < n * n) ? gw[b] : gx[b - n * n], t);
      if (gap) begin
        @(posedge i_clk); #1;
      end
    end
    t_last = t;
  endtask

  task automatic check_outputs(input string tag, input int n, input int t, input int bp);
    int first;
    int nd;
    bit seen;
    seen  = 1'b0;
    first = -1;
    nd    = 2 * n - 1;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge i_clk);
      if (o_out_valid) begin
        seen  = 1'b1;
        first = cyc;
      end
    end
    chk({tag, "_first_vld"}, first, t + n * n + 3);
    if (bp > 0) begin
      for (int k = 0; k < bp; k++) begin
        chk({tag, "_bp_hold"}, o_out_valid ? longint'(o_out_data) : -1, exp_d[0]);
        if (k < bp - 1) @(negedge i_clk);
      end
      @(posedge i_clk); #1;
      i_out_ready = 1'b1;
    end
    for (int k = 0; k < 200 && q_dat.size() < nd; k++) begin
      @(negedge i_clk); #1;
    end
    @(negedge i_clk);
    chk({tag, "_vld_after"}, o_out_valid, 0);
    chk({tag, "_rdy_after"}, o_in_ready, 1);
    chk({tag, "_count"}, q_dat.size(), nd);
    for (int i = 0; i < nd; i++) begin
      chk($sformatf("%s_D%0d", tag, i), (i < q_dat.size()) ? q_dat[i] : -1, exp_d[i]);
    end
    if (bp == 0 && q_cyc.size() == nd) chk({tag, "_span"}, q_cyc[nd-1] - q_cyc[0], nd - 1);
    q_dat.delete();
    q_cyc.delete();
  endtask

  task automatic set_2x2();
    for (int b = 0; b < 4; b++) begin
      gw[b] = DATA_W'(b + 1);
      gx[b] = DATA_W'(b + 5);
    end
  endtask

  task automatic exp_2x2();
    exp_d[0] = 23; exp_d[1] = 65; exp_d[2] = 46;
  endtask

  task automatic set_4x4();
    for (int b = 0; b < 16; b++) begin
      gw[b] = (b / 4 == b % 4) ? DATA_W'(1) : DATA_W'(0);
      gx[b] = DATA_W'(b + 1);
    end
  endtask

  task automatic exp_4x4();
    exp_d[0] = 1;  exp_d[1] = 7;  exp_d[2] = 18; exp_d[3] = 34;
    exp_d[4] = 33; exp_d[5] = 27; exp_d[6] = 16;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t2;
    t = 0;
    t2 = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_in_ready", o_in_ready, 1);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_data", o_out_data, 0);

    // 2x2 basic
    set_2x2(); exp_2x2();
    load(2'd0, 2, 1'b0, t);
    check_outputs("p2", 2, t, 0);

    // 4x4 identity with gapped input
    set_4x4(); exp_4x4();
    load(2'd1, 4, 1'b1, t);
    check_outputs("p4gap", 4, t, 0);

    // 8x8 all most-negative values
    for (int b = 0; b < 64; b++) begin
      gw[b] = 16'h8000;
      gx[b] = 16'h8000;
    end
    for (int d = 0; d < 15; d++) begin
      exp_d[d] = (longint'(1) << 33) * longint'(((d < 14 - d) ? d : 14 - d) + 1);
    end
    load(2'd2, 8, 1'b0, t);
    check_outputs("p8", 8, t, 0);

    // Back-pressure on the first output
    set_2x2(); exp_2x2();
    i_out_ready = 1'b0;
    load(2'd0, 2, 1'b0, t);
    check_outputs("bp", 2, t, 5);

    // Reset during CALC of a 4x4 problem
    set_4x4();
    load(2'd1, 4, 1'b0, t);
    repeat (5) @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst2_in_ready", o_in_ready, 1);
    chk("rst2_out_valid", o_out_valid, 0);
    chk("rst2_out_data", o_out_data, 0);
    chk("rst2_no_output", q_dat.size(), 0);
    set_2x2(); exp_2x2();
    load(2'd0, 2, 1'b0, t);
    check_outputs("postrst", 2, t, 0);

    // Back-to-back: 2x2 beats held pending while the 4x4 computes and drains
    set_4x4(); exp_4x4();
    load(2'd1, 4, 1'b0, t);
    set_2x2();
    fork
      check_outputs("b2b4", 4, t, 0);
      load(2'd0, 2, 1'b0, t2);
    join
    exp_2x2();
    check_outputs("b2b2", 2, t2, 0);

    chk("invariants", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
